// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor; one WIDTH/STAGES segment resolved per stage.
// Define CLA_PIPE_FLAGS_EN to build the registered ovf/zero flags (tied to 0 otherwise).
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int SEG    = int'(WIDTH / STAGES);
  localparam int BLK    = int'(BLOCK);
  localparam int GROUPS = SEG / BLK;
  localparam int LAST   = int'(STAGES) - 1;

  if ((STAGES < 1) || ((WIDTH % (STAGES * BLOCK)) != 0)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of STAGES*BLOCK");
  end

  // Lookahead inside each BLOCK-bit group, group carries chained across the segment.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] g, p, s;
    logic           c_grp, c_bit, gg, pr;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    c_grp = ci;
    for (int grp = 0; grp < GROUPS; grp++) begin
      for (int i = 0; i < BLK; i++) begin
        c_bit = 1'b0;
        pr    = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          c_bit = c_bit | (g[grp*BLK + j] & pr);
          pr    = pr & p[grp*BLK + j];
        end
        c_bit = c_bit | (pr & c_grp);
        s[grp*BLK + i] = p[grp*BLK + i] ^ c_bit;
      end
      gg = 1'b0;
      pr = 1'b1;
      for (int j = BLK - 1; j >= 0; j--) begin
        gg = gg | (g[grp*BLK + j] & pr);
        pr = pr & p[grp*BLK + j];
      end
      c_grp = gg | (pr & c_grp);
    end
    return {c_grp, s};
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [SEG:0]      res   [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] c_d;
  logic [STAGES:0]   adv;
  logic              adv_acc;

  always_comb begin
    src_a = '{default: '0};
    src_b = '{default: '0};
    src_s = '{default: '0};
    s_d   = '{default: '0};
    res   = '{default: '0};
    src_c = '0;
    src_v = '0;
    c_d   = '0;
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c[0] = bus.sub | bus.cin;
    src_v[0] = bus.in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      src_v[k] = valid_q[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      res[k] = seg_add(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
      s_d[k] = src_s[k];
      s_d[k][k*SEG +: SEG] = res[k][SEG-1:0];
      c_d[k] = res[k][SEG];
    end
  end

  // A stage may load when it is empty or its successor is loading this cycle.
  always_comb begin
    adv_acc     = bus.out_ready;
    adv         = '0;
    adv[STAGES] = adv_acc;
    for (int k = LAST; k >= 0; k--) begin
      adv_acc = !valid_q[k] || adv_acc;
      adv[k]  = adv_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          valid_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
    end
  end

  // Operand bits already summed are dead downstream; fold them into a sink.
  logic unused_regs;
  always_comb begin
    unused_regs = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      unused_regs = unused_regs ^ (^a_q[k]) ^ (^b_q[k]);
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q, zero_q, ovf_d, zero_d;

  always_comb begin
    ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
             (s_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_d = (s_d[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv[LAST] && src_v[LAST]) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-sequence bench for cla_pipe_adder with a queue scoreboard and arithmetic model.
module tb_cla_pipe_adder;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned BLOCK  = 4;
  localparam int unsigned STAGES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_adder #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK),
    .STAGES(STAGES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t             m;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    bp     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, (sub | cin)};
    m.sum  = full[WIDTH-1:0];
    m.cout = full[WIDTH];
`ifdef CLA_PIPE_FLAGS_EN
    m.ovf  = (a[WIDTH-1] == bp[WIDTH-1]) && (m.sum[WIDTH-1] != a[WIDTH-1]);
    m.zero = (m.sum == '0);
`else
    m.ovf  = 1'b0;
    m.zero = 1'b0;
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_out++;
    n_assert++;
    assert (q.size() != 0) else begin
      n_fail++;
      $error("FAIL unexpected_output: observed sum 0x%0h expected no result", bus.sum);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check("sum", bus.sum, e.sum);
      check("cout", WIDTH'(bus.cout), WIDTH'(e.cout));
      check("ovf", WIDTH'(bus.ovf), WIDTH'(e.ovf));
      check("zero", WIDTH'(bus.zero), WIDTH'(e.zero));
    end
  endtask

  // Observe both transfers mid-cycle, then step past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) check_out();
    if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  task automatic drive_rand();
    drive(WIDTH'({$urandom(), $urandom()}), WIDTH'({$urandom(), $urandom()}),
          1'($urandom()), 1'($urandom()));
  endtask

  task automatic run_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
    int lat;
    bus.out_ready = 1'b1;
    drive(a, b, cin, sub);
    check("single_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("latency", WIDTH'(lat), WIDTH'(STAGES - 1));
    cycle();
    check("single_drained", WIDTH'(q.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  logic [31:0]      dir_a   [5] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0005,
                                    32'h0000_0005, 32'h1234_5678};
  logic [31:0]      dir_b   [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007,
                                    32'h0000_0007, 32'h0FED_CBA9};
  logic             dir_cin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic             dir_sub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int               n0;
    int               acc;
    logic [WIDTH-1:0] held;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", WIDTH'(bus.out_valid), '0);
    check("rst_sum", bus.sum, '0);
    check("rst_cout", WIDTH'(bus.cout), '0);
    check("rst_ovf", WIDTH'(bus.ovf), '0);
    check("rst_zero", WIDTH'(bus.zero), '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));

    // Directed corner cases, one at a time
    for (int i = 0; i < 5; i++) begin
      run_single(WIDTH'(dir_a[i]), WIDTH'(dir_b[i]), dir_cin[i], dir_sub[i]);
    end

    // Back-to-back stream
    n0 = n_out;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      check("stream_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
      check("stream_out_valid", WIDTH'(bus.out_valid), WIDTH'(i >= int'(STAGES)));
      cycle();
    end
    bus.in_valid = 1'b0;
    repeat (STAGES + 1) cycle();
    check("stream_count", WIDTH'(n_out - n0), WIDTH'(16));
    check("stream_drained", WIDTH'(q.size()), '0);

    // Backpressure: fill, hold, drain
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < int'(STAGES) + 3; i++) begin
      drive_rand();
      if (bus.in_ready) acc++;
      cycle();
    end
    check("bp_accepted", WIDTH'(acc), WIDTH'(STAGES));
    check("bp_in_ready", WIDTH'(bus.in_ready), '0);
    check("bp_out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
    held = bus.sum;
    repeat (3) cycle();
    check("bp_sum_stable", bus.sum, held);
    check("bp_valid_held", WIDTH'(bus.out_valid), WIDTH'(1));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 2) cycle();
    check("bp_drained", WIDTH'(q.size()), '0);

    // Reset with two operations in flight
    drive_rand();
    cycle();
    drive_rand();
    cycle();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", WIDTH'(bus.out_valid), '0);
    check("midrst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    check("midrst_sum", bus.sum, '0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    repeat (STAGES + 3) cycle();
    check("no_stale", WIDTH'(n_out - n0), '0);

    // Pipe still works after reset
    run_single(WIDTH'(32'hFFFF_FFFF), WIDTH'(32'h0000_0001), 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake, for the RV32IM execute stage and the multiplier's partial-product reduction. The operand width is split into `STAGES` equal segments. Each segment is built from `BLOCK`-bit lookahead groups and is resolved in its own register stage, with the carry registered between stages. Throughput is one operation per cycle when downstream is not stalling. Optional signed-overflow and zero flags are controlled by a compile-time macro.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. `WIDTH % (STAGES*BLOCK) == 0` is required, and elaboration fails otherwise.
- `BLOCK`, 4: lookahead group width in bits, used for group generate/propagate.
- `STAGES`, 2: number of pipeline stages, which equals the latency in cycles. The minimum is 1.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: the operand set is valid.
- `in_ready`, out, 1: the adder accepts an operand set this cycle.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `cin`, in, 1: carry-in. It is ignored when `sub`=1.
- `sub`, in, 1: 0 computes a+b+cin; 1 computes a+~b+1 (a−b).
- `out_valid`, out, 1: the result is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `sum`, out, `WIDTH`: the result.
- `cout`, out, 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf`, out, 1: two's-complement signed overflow.
- `zero`, out, 1: `sum == 0`.

## Operation
- Segment width is `SEG = WIDTH/STAGES`. Stage k adds bits `[k*SEG +: SEG]` using `SEG/BLOCK` lookahead groups, with a group-level carry chain inside the segment.
- Stage k carry-in:
  - For k=0 it is `sub ? 1 : cin`.
  - For k>0 it is the registered carry-out of stage k−1.
- In stage 0, `b` is replaced by `~b` when `sub`=1.
- Bits not yet summed travel forward in a skew register and are consumed by their stage. Bits already summed travel forward in a de-skew register, so all `WIDTH` result bits appear on the same cycle.
- Each stage holds one valid bit plus data. Stage k loads from stage k−1 (or from the input for k=0) when `!valid[k] || advance[k+1]`. The last stage advances on `out_ready`.
- Stall rule: a stage advances only if it is empty or its successor advances. Backpressure ripples combinationally from `out_ready` to `in_ready`. No bubble is ever inserted while the pipe is stalled.
- `in_ready = !valid[0] || advance[1]` (for `STAGES`=1: `!valid[0] || out_ready`).
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - Input and output transfers in the same cycle are legal, and a full pipe then sustains 1 op/cycle.
- Flags:
  - `ovf = (a_msb == b'_msb) && (sum_msb != a_msb)`, where `b'` is the possibly inverted b.
  - `zero` is computed in the final stage.
- Wrap-around: results are modulo 2^WIDTH, and carry beyond `cout` is discarded.
- `sum`, `cout`, `ovf`, `zero` are registered. They hold their value while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync-safe deassert in the parent): all `valid` bits = 0, `sum` = 0, `cout` = 0, `ovf` = 0, `zero` = 0. With `valid[0]`=0, `in_ready` is 1 as soon as reset deasserts.
- Latency: an operand accepted on edge N gives `out_valid`=1 after edge N+`STAGES−1`, i.e. visible in cycle N+`STAGES`.
- Reset mid-operation: all in-flight operations are dropped and no partial result is emitted.
- Empty pipe with `out_ready`=0: input is still accepted until every stage is full. At most `STAGES` operations are outstanding.
- Outputs are stable under stall. `out_valid` never falls without an output transfer.

## Configuration
- `CLA_PIPE_FLAGS_EN`:
  - Defined: `ovf` and `zero` are computed and registered as specified.
  - Undefined: the flag logic and registers are not built, `ovf` and `zero` are tied to 0, and the ports remain for interface stability. `sum` and `cout` timing is unchanged.

## Test plan
- Reset, then a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0, `out_ready`=1 → after `STAGES` cycles sum=0x0000_0000, cout=1, zero=1, ovf=0.
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 → sum=0x8000_0000, ovf=1, cout=0. Subtract a=0x0000_0005, b=0x0000_0007 → sum=0xFFFF_FFFE, cout=0 (borrow).
- Back-to-back stream of 16 random ops with `out_ready`=1 → one result per cycle, in order, matching the reference model, with `in_ready` constantly 1.
- Hold `out_ready`=0 while driving `in_valid`=1 → exactly `STAGES` ops are accepted and then `in_ready`=0. The held `sum` is stable. Release `out_ready` → all results drain in order.
- Assert `rst_n`=0 with 2 ops in flight → `out_valid`=0 immediately. After release, no stale result appears.
- Repeat the above with `WIDTH`=64, `BLOCK`=8, `STAGES`=4, and with the macro undefined (`ovf`/`zero` stay 0).
